// File: rtl/uart_rx.sv
// 8N1 serial receiver feeding a byte FIFO write port.
// Good frames pulse WEN with the byte on WriteData; a low stop bit pulses FrameErr.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       RX,
  output logic [7:0] WriteData,
  output logic       WEN,
  output logic       FrameErr
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(H);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_rx_meta;
  logic          r_rx_s;

  // Both flops reset high so an idle line never looks like a start bit.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two stages distinct flops.
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      WriteData <= 8'h00;
      WEN       <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so they are single-cycle pulses.
      WEN      <= 1'b0;
      FrameErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              WriteData <= r_shift;
              WEN       <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              FrameErr <= 1'b1;
              r_state  <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A line held low after a bad stop bit must rise before the next start.
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit, with a depth-8 FIFO model
// standing in for the downstream byte FIFO.
module tb_uart_rx;

  localparam int CPB      = 8;
  localparam int H        = (CPB - 1) / 2;
  localparam int LAT      = H + 4 + 9 * CPB;  // drive-negedge count to WEN/FrameErr
  localparam int FIFO_DEP = 8;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       CLK;
  logic       RSTN;
  logic       RX;
  logic [7:0] WriteData;
  logic       WEN;
  logic       FrameErr;

  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  exp_t        exp_q[$];
  int unsigned fe_q[$];
  logic [7:0]  last_exp;
  logic [7:0]  fifo_q[$];
  bit          fifo_en;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .RX        (RX),
    .WriteData (WriteData),
    .WEN       (WEN),
    .FrameErr  (FrameErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Output monitor: every strobe is matched against the scoreboard.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (WEN && FrameErr) check("wen_fe_exclusive", 32'(WEN & FrameErr), 32'd0);
      if (WEN) begin
        check("wen_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("wen_data", 32'(WriteData), 32'(e.data));
          check("wen_cycle", cyc, e.cyc);
          last_exp = e.data;
        end
        if (fifo_en && fifo_q.size() < FIFO_DEP) fifo_q.push_back(WriteData);
      end
      if (FrameErr) begin
        check("fe_expected", 32'(fe_q.size() != 0), 32'd1);
        if (fe_q.size() != 0) check("fe_cycle", cyc, fe_q.pop_front());
        check("fe_data_hold", 32'(WriteData), 32'(last_exp));
      end
    end
  end

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame; good frames go to the data scoreboard, bad stop bits to the error queue.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    @(negedge CLK);
    if (stop_bit) begin
      e.data = b;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
    end else begin
      fe_q.push_back(cyc + LAT);
    end
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = stop_bit;
    repeat (CPB - 1) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] seq[3];
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    last_exp = 8'h00;
    fifo_en  = 1'b0;
    RX       = 1'b1;
    RSTN     = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_writedata", 32'(WriteData), 32'h00);
    check("rst_wen", 32'(WEN), 32'd0);
    check("rst_frameerr", 32'(FrameErr), 32'd0);
    RSTN = 1'b1;
    idle(10);

    // Single byte
    send_frame(8'hA5, 1'b1);
    idle(20);

    // Back-to-back stream, one stop bit between frames
    seq = '{8'h00, 8'hFF, 8'h3C};
    foreach (seq[i]) send_frame(seq[i], 1'b1);
    idle(20);

    // Glitch shorter than half a bit
    @(negedge CLK);
    RX = 1'b0;
    repeat (2) @(negedge CLK);
    idle(3 * CPB * 10);

    // Framing error, line held low, then a clean frame
    send_frame(8'h55, 1'b0);
    RX = 1'b0;
    repeat (30) @(negedge CLK);
    idle(20);
    send_frame(8'h12, 1'b1);
    idle(20);

    // Reset during data bit 4 of 8'hC3
    @(negedge CLK);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX = 1'(8'hC3 >> i);
      repeat (CPB) @(negedge CLK);
    end
    RX = 1'(8'hC3 >> 4);
    repeat (CPB / 2) @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("midrst_writedata", 32'(WriteData), 32'h00);
    check("midrst_wen", 32'(WEN), 32'd0);
    check("midrst_frameerr", 32'(FrameErr), 32'd0);
    last_exp = 8'h00;
    RX = 1'b1;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    idle(3 * CPB * 10);
    send_frame(8'h81, 1'b1);
    idle(20);

    // FIFO integration: nine writes into a depth-8 FIFO, then drain
    fifo_q.delete();
    fifo_en = 1'b1;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    idle(20);
    fifo_en = 1'b0;
    check("fifo_level", 32'(fifo_q.size()), 32'(FIFO_DEP));
    for (int i = 1; i <= FIFO_DEP; i++) begin
      if (fifo_q.size() != 0) check("fifo_read", 32'(fifo_q.pop_front()), 32'(i));
    end

    // Bounded drain: anything still queued never appeared on the outputs
    idle(3 * CPB * 10);
    check("sb_wen_pending", 32'(exp_q.size()), 32'd0);
    check("sb_fe_pending", 32'(fe_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
